// File: rtl/ball_judge.sv
// Ball/paddle/floor judge: scores paddle hits, counts lives and sequences
// the serve/play/game-over flow for the bouncing-square animator.
module ball_judge #(
  parameter int unsigned D_HEIGHT     = 480,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ani_stb,
  input  logic               i_start,
  input  logic [11:0]        i_bx1,
  input  logic [11:0]        i_bx2,
  input  logic [11:0]        i_by1,
  input  logic [11:0]        i_by2,
  input  logic [11:0]        i_px1,
  input  logic [11:0]        i_px2,
  input  logic [11:0]        i_py1,
  output logic               o_animate,
  output logic               o_ball_rst,
  output logic               o_hit,
  output logic               o_miss,
  output logic [SCORE_W-1:0] o_score,
  output logic [3:0]         o_lives,
  output logic [1:0]         o_state
);

  localparam int unsigned      CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [11:0]      FLOOR_ROW  = 12'(D_HEIGHT - 1);
  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_q, lock_d;
  logic               animate_q, animate_d;
  logic               ball_rst_q, ball_rst_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic hit_cond, miss_cond, scored;

  assign hit_cond  = (i_by2 >= i_py1) && (i_by1 < i_py1) &&
                     (i_bx2 >= i_px1) && (i_bx1 <= i_px2);
  assign miss_cond = (i_by2 >= FLOOR_ROW);
  assign scored    = hit_cond && !lock_q;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    ball_rst_d = 1'b0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          ball_rst_d = 1'b1;
          score_d    = '0;
          lives_d    = LIVES_INIT;
          cnt_d      = '0;
          lock_d     = 1'b0;
          state_d    = S_SERVE;
        end
      end
      S_SERVE: begin
        if (i_ani_stb) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (i_ani_stb) begin
          // Lock is held from a scored hit until the ball rises above the paddle top.
          if (scored) begin
            hit_d  = 1'b1;
            lock_d = 1'b1;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end else if (i_by2 < i_py1) begin
            lock_d = 1'b0;
          end
          if (miss_cond && !scored) begin
            miss_d  = 1'b1;
            lives_d = lives_q - 4'd1;
            if (lives_q == 4'd1) begin
              state_d = S_OVER;
            end else begin
              ball_rst_d = 1'b1;
              lock_d     = 1'b0;
              cnt_d      = '0;
              state_d    = S_SERVE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    animate_d = (state_d == S_PLAY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      score_q    <= '0;
      lives_q    <= LIVES_INIT;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      animate_q  <= 1'b0;
      ball_rst_q <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      animate_q  <= animate_d;
      ball_rst_q <= ball_rst_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign o_animate  = animate_q;
  assign o_ball_rst = ball_rst_q;
  assign o_hit      = hit_q;
  assign o_miss     = miss_q;
  assign o_score    = score_q;
  assign o_lives    = lives_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_ball_judge.sv
// Scoreboard bench for ball_judge: every change of the output snapshot is
// popped against a queue of hand-computed expected snapshots.
module tb_ball_judge;

  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0;
  logic          start = 1'b0;
  logic [11:0]   bx1 = '0, bx2 = '0, by1 = '0, by2 = '0;
  logic [11:0]   px1 = 12'd280, px2 = 12'd360, py1 = 12'd460;
  logic          animate, ball_rst, hit, miss;
  logic [SW-1:0] score;
  logic [3:0]    lives;
  logic [1:0]    state;

  typedef struct packed {
    logic [1:0]    st;
    logic [SW-1:0] sc;
    logic [3:0]    lv;
    logic          an, br, hi, mi;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    fails  = 0;

  ball_judge #(
    .D_HEIGHT(480), .LIVES(3), .SCORE_W(SW), .SERVE_FRAMES(60)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(stb), .i_start(start),
    .i_bx1(bx1), .i_bx2(bx2), .i_by1(by1), .i_by2(by2),
    .i_px1(px1), .i_px2(px2), .i_py1(py1),
    .o_animate(animate), .o_ball_rst(ball_rst), .o_hit(hit), .o_miss(miss),
    .o_score(score), .o_lives(lives), .o_state(state)
  );

  always #5 clk = ~clk;

  function automatic snap_t cur_snap();
    return '{st: state, sc: score, lv: lives, an: animate, br: ball_rst, hi: hit, mi: miss};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d sc=%0d lv=%0d an=%0b br=%0b hit=%0b miss=%0b",
                     s.st, s.sc, s.lv, s.an, s.br, s.hi, s.mi);
  endfunction

  task automatic push(input int st, input int sc, input int lv, input bit an);
    exp_q.push_back('{st: 2'(st), sc: SW'(sc), lv: 4'(lv), an: an, br: 1'b0, hi: 1'b0, mi: 1'b0});
  endtask

  // Pulse snapshot followed by the same snapshot with pulses dropped a cycle later.
  task automatic push_pulse(input int st, input int sc, input int lv, input bit an,
                            input bit br, input bit hi, input bit mi);
    exp_q.push_back('{st: 2'(st), sc: SW'(sc), lv: 4'(lv), an: an, br: br, hi: hi, mi: mi});
    push(st, sc, lv, an);
  endtask

  task automatic strobe();
    @(negedge clk); stb = 1'b1;
    @(negedge clk); stb = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic serve();
    repeat (60) strobe();
  endtask

  task automatic ball(input int x1, input int x2, input int y1, input int y2);
    bx1 = 12'(x1); bx2 = 12'(x2); by1 = 12'(y1); by2 = 12'(y2);
  endtask

  // Monitor: any change in the output snapshot is an event to be scored.
  initial begin
    snap_t prev, cur, e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = cur_snap();
      if (cur !== prev) begin
        prev = cur;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event got %s required none", fmt(cur));
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL event got %s required %s", fmt(cur), fmt(e));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t rs;
    rs = '{st: 2'd0, sc: '0, lv: 4'd3, an: 1'b0, br: 1'b0, hi: 1'b0, mi: 1'b0};

    push(0, 0, 3, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_pulse(1, 0, 3, 0, 1, 0, 0);
    do_start();
    push(2, 0, 3, 1);
    serve();

    // Descending onto the paddle scores once per descent.
    ball(300, 340, 440, 462);
    push_pulse(2, 1, 3, 1, 0, 1, 0);
    strobe();
    repeat (3) strobe();
    by2 = 12'd400; strobe();
    by2 = 12'd462;
    push_pulse(2, 2, 3, 1, 0, 1, 0);
    strobe();
    for (int i = 0; i < 3; i++) begin
      by2 = 12'd400; strobe();
      by2 = 12'd462;
      push_pulse(2, 3, 3, 1, 0, 1, 0);
      strobe();
    end

    // Simultaneous hit and floor contact: hit wins.
    py1 = 12'd470;
    ball(300, 340, 460, 400); strobe();
    by2 = 12'd479;
    push_pulse(2, 3, 3, 1, 0, 1, 0);
    strobe();

    // Floor misses until game over.
    py1 = 12'd460;
    ball(0, 40, 460, 479);
    for (int lv = 2; lv >= 1; lv--) begin
      push_pulse(1, 3, lv, 0, 1, 0, 1);
      strobe();
      push(2, 3, lv, 1);
      serve();
    end
    push_pulse(3, 3, 0, 0, 0, 0, 1);
    strobe();
    repeat (3) strobe();

    // Restart from OVER, then reset asynchronously over a hit pulse.
    push_pulse(1, 0, 3, 0, 1, 0, 0);
    do_start();
    push(2, 0, 3, 1);
    serve();
    ball(300, 340, 440, 462);
    push(0, 0, 3, 0);
    @(negedge clk); stb = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; stb = 1'b0;
    #1;
    checks++;
    if (cur_snap() !== rs) begin
      fails++;
      $display("FAIL async_reset got %s required %s", fmt(cur_snap()), fmt(rs));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events got %0d required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ball_judge.md
Name: ball_judge

Overview:
- Consumer of the bouncing-square bounding box: compares ball edges against the paddle box and the floor once per animation strobe.
- Scores paddle hits, counts lives and runs the serve/play/game-over flow.
- Drives the square's animate enable and a one-cycle ball reset back to it.
- Sits between the square animator and the display/score readout in the top level.

Parameters:
- D_HEIGHT, 480, display height in pixels; floor row is D_HEIGHT-1.
- LIVES, 3, lives per game (1..15).
- SCORE_W, 8, score width; score saturates at 2^SCORE_W-1.
- SERVE_FRAMES, 60, animation strobes the ball is held before each serve (>=1).

Ports:
- i_clk  in  1  base clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ani_stb  in  1  animation strobe, one i_clk cycle per frame.
- i_start  in  1  start/restart request, level, sampled every cycle.
- i_bx1, i_bx2  in  12  ball left/right edge.
- i_by1, i_by2  in  12  ball top/bottom edge.
- i_px1, i_px2  in  12  paddle left/right edge.
- i_py1  in  12  paddle top edge.
- o_animate  out  1  enable for square motion.
- o_ball_rst  out  1  one-cycle pulse returning the square to its start position.
- o_hit  out  1  one-cycle pulse per scored paddle hit.
- o_miss  out  1  one-cycle pulse per floor miss.
- o_score  out  SCORE_W  hit count.
- o_lives  out  4  remaining lives.
- o_state  out  2  0=IDLE 1=SERVE 2=PLAY 3=OVER.

Behaviour:
- Reset (async on i_rst_n low, released synchronously to the design):
  - state IDLE; o_score=0; o_lives=LIVES.
  - o_animate, o_ball_rst, o_hit, o_miss all 0.
  - serve counter 0; hit_lock 0.
- All outputs are registered. Pulses assert the cycle after the triggering cycle and are exactly 1 cycle wide.
- o_animate = 1 only while in PLAY, updated on the cycle the state register changes.
- IDLE:
  - i_start=1 -> o_ball_rst pulse, score=0, lives=LIVES, serve counter=0, hit_lock=0, enter SERVE.
- SERVE:
  - Each i_ani_stb increments the serve counter.
  - A strobe arriving with counter==SERVE_FRAMES-1 enters PLAY; the counter clears.
  - Entry to PLAY happens exactly SERVE_FRAMES strobes after entering SERVE.
  - i_start is ignored.
- PLAY: evaluation only on cycles with i_ani_stb=1, using that cycle's inputs.
  - hit_cond = (i_by2 >= i_py1) && (i_by1 < i_py1) && (i_bx2 >= i_px1) && (i_bx1 <= i_px2). All compares are unsigned 12-bit.
  - hit_cond && !hit_lock:
    - o_hit pulse; score += 1, saturating at all-ones (o_hit still pulses at saturation).
    - hit_lock=1.
  - hit_lock clears on any strobe with i_by2 < i_py1, so there is one score per descent.
  - miss_cond = i_by2 >= D_HEIGHT-1.
    - Miss is honoured only when no hit is scored on the same strobe. A simultaneous hit wins and the miss is dropped.
  - On a miss: o_miss pulse; lives -= 1.
    - If lives was 1 -> lives=0, enter OVER, no o_ball_rst.
    - Otherwise -> o_ball_rst pulse, hit_lock=0, serve counter=0, enter SERVE.
  - i_start is ignored.
- OVER:
  - o_animate=0; score and lives=0 are held.
  - i_start=1 behaves exactly as in IDLE.
- i_ani_stb outside SERVE/PLAY has no effect.
- Async reset mid-PLAY or mid-SERVE takes effect immediately. Any pulse in flight is cancelled (forced 0).

Test Plan:
- Reset with i_rst_n=0, then release, then assert i_start for one cycle:
  - o_ball_rst=1 for 1 cycle, o_state=1, o_lives=3, o_animate=0.
  - After exactly 60 strobes: o_state=2, o_animate=1.
- In PLAY, paddle px1=280 px2=360 py1=460, ball bx1=300 bx2=340, by1=440 by2=462, strobe:
  - o_hit pulse, o_score=1.
  - Hold same box for 3 more strobes -> score stays 1.
  - Move by2=400, then by2=462 -> score=2.
- Ball bx1=0 bx2=40 (no overlap), by2=479, strobe:
  - o_miss and o_ball_rst pulse, o_lives=2, o_state=1.
  - Repeat until lives=0 -> o_state=3, no o_ball_rst on the last miss, o_animate=0.
- Same strobe with hit_cond true and by2=479 (py1=470, by1=460):
  - o_hit only, o_lives unchanged, state stays PLAY.
- SCORE_W=2, 5 scored hits -> o_score=3 after the third hit and remains 3. o_hit pulses all 5 times.
- In OVER, i_start -> score=0, lives=3, SERVE. In PLAY, pull i_rst_n low between strobes -> outputs return to reset values immediately, no pulse emitted.
